// File: rtl/tick_timer.sv
// Programmable timebase with an up/down tick counter, compare match and auto-reload.
// Optional lap capture is enabled by defining TICK_TIMER_LAP_EN.
module tick_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] cmp_val,
`ifdef TICK_TIMER_LAP_EN
  input  logic             lap,
  output logic [CNT_W-1:0] lap_count,
  output logic             lap_valid,
`endif
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state,
  output logic             tick,
  output logic             wrap,
  output logic             match,
  output logic             expired
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("tick_timer: CLK_HZ/TICK_HZ must be at least 2");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, EXPIRED = 2'd3} state_t;

  state_t           st, st_n;
  logic [PW-1:0]    psc, psc_n;
  logic [CNT_W-1:0] cnt_n;
  logic             tick_n, wrap_n, match_n;

  assign state = st;

  // Control priority: clear > load > stop > start; the prescaler only advances
  // in RUN cycles with no control pulse, so stop freezes it on the stop edge.
  always_comb begin
    st_n    = st;
    cnt_n   = count;
    psc_n   = psc;
    tick_n  = 1'b0;
    wrap_n  = 1'b0;
    match_n = 1'b0;
    if (clear) begin
      st_n  = IDLE;
      cnt_n = '0;
      psc_n = '0;
    end else if (load) begin
      cnt_n = load_val;
      psc_n = '0;
      if (st == EXPIRED) st_n = IDLE;
    end else if (stop) begin
      if (st == RUN) st_n = HOLD;
    end else if (start && (st == IDLE || st == HOLD)) begin
      st_n = RUN;
    end else if (st == RUN) begin
      if (psc != PMAX) begin
        psc_n = psc + PW'(1);
      end else begin
        psc_n = '0;
        if (!dir) begin
          cnt_n  = count + CNT_W'(1);
          tick_n = 1'b1;
          wrap_n = (count == '1);
        end else if (count != '0) begin
          cnt_n  = count - CNT_W'(1);
          tick_n = 1'b1;
        end else if (auto_reload) begin
          cnt_n  = load_val;
          tick_n = 1'b1;
          wrap_n = 1'b1;
        end else begin
          st_n = EXPIRED;
        end
        match_n = tick_n && (cnt_n == cmp_val);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      psc     <= '0;
      count   <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      match   <= 1'b0;
      expired <= 1'b0;
    end else begin
      st      <= st_n;
      psc     <= psc_n;
      count   <= cnt_n;
      tick    <= tick_n;
      wrap    <= wrap_n;
      match   <= match_n;
      expired <= (st_n == EXPIRED);
    end
  end

`ifdef TICK_TIMER_LAP_EN
  // Captures the pre-update count, so a lap on a tick edge sees the old value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lap_count <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= lap && (st == RUN || st == HOLD);
      if (lap && (st == RUN || st == HOLD)) lap_count <= count;
    end
  end
`endif

endmodule

// File: tb/tb_tick_timer.sv
// Directed plus randomized bench for tick_timer (PRESCALE = 10, CNT_W = 4) against a
// behavioural model; every cycle all outputs are compared with the model.
module tb_tick_timer;
  localparam int P = 10;
  localparam int M = 16;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear, load, dir, auto_reload, lap;
  logic [3:0] load_val, cmp_val, count;
  logic [1:0] state;
  logic       tick, wrap, match, expired;
`ifdef TICK_TIMER_LAP_EN
  logic [3:0] lap_count;
  logic       lap_valid;
`endif

  int nchk = 0;
  int nerr = 0;

  // reference model state: count, state code, RUN cycles elapsed in current period
  int m_cnt = 0, m_st = 0, m_ph = 0, m_lapc = 0;
  bit m_tick = 0, m_wrap = 0, m_match = 0, m_lapv = 0;

  tick_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val), .dir(dir), .auto_reload(auto_reload), .cmp_val(cmp_val),
`ifdef TICK_TIMER_LAP_EN
    .lap(lap), .lap_count(lap_count), .lap_valid(lap_valid),
`endif
    .count(count), .state(state), .tick(tick), .wrap(wrap), .match(match),
    .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    m_tick = 0; m_wrap = 0; m_match = 0; m_lapv = 0;
    if (rst) begin
      m_cnt = 0; m_st = 0; m_ph = 0; m_lapc = 0;
    end else if (clear) begin
      m_cnt = 0; m_st = 0; m_ph = 0; m_lapc = 0;
    end else begin
      if (lap && (m_st == 1 || m_st == 2)) begin
        m_lapc = m_cnt; m_lapv = 1;
      end
      if (load) begin
        m_cnt = int'(load_val); m_ph = 0;
        if (m_st == 3) m_st = 0;
      end else if (stop) begin
        if (m_st == 1) m_st = 2;
      end else if (start && (m_st == 0 || m_st == 2)) begin
        m_st = 1;
      end else if (m_st == 1) begin
        m_ph++;
        if (m_ph == P) begin
          m_ph = 0;
          if (!dir) begin
            m_cnt = (m_cnt + 1) % M; m_tick = 1; m_wrap = (m_cnt == 0);
          end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1; m_tick = 1;
          end else if (auto_reload) begin
            m_cnt = int'(load_val); m_tick = 1; m_wrap = 1;
          end else begin
            m_st = 3;
          end
          if (m_tick) m_match = (m_cnt == int'(cmp_val));
        end
      end
    end
  endtask

  // One clock: model, edge, drop pulses, compare every output.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    {rst, start, stop, clear, load, lap} = '0;
    chk("count", 32'(count), m_cnt);
    chk("state", 32'(state), m_st);
    chk("tick", 32'(tick), 32'(m_tick));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("match", 32'(match), 32'(m_match));
    chk("expired", 32'(expired), 32'(m_st == 3));
`ifdef TICK_TIMER_LAP_EN
    chk("lap_valid", 32'(lap_valid), 32'(m_lapv));
    chk("lap_count", 32'(lap_count), m_lapc);
`endif
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin cyc(); n++; end while (!tick && n < 12);
    chk("tick_seen", 32'(tick), 1);
  endtask

  initial begin
    int n;
    int exp_cnt[6]  = '{1, 0, 2, 1, 0, 2};
    int exp_wrap[6] = '{0, 0, 1, 0, 0, 1};
    {rst, start, stop, clear, load, lap, dir, auto_reload} = '0;
    load_val = 4'd0;
    cmp_val  = 4'd3;

    // reset
    rst = 1; cyc();
    rst = 1; cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_pulses", 32'({tick, wrap, match, expired}), 0);

    // first tick exactly PRESCALE cycles after start
    start = 1; cyc();
    for (int i = 0; i < P - 1; i++) begin
      cyc();
      chk("early_tick", 32'(tick), 0);
    end
    cyc();
    chk("first_tick", 32'(tick), 1);
    chk("first_count", 32'(count), 1);

    // up count, match at 3, wrap on 16th tick
    wait_tick();
    wait_tick();
    chk("match_at3", 32'(match), 1);
    chk("match_cnt", 32'(count), 3);
    for (int i = 0; i < 13; i++) wait_tick();
    chk("wrap_cnt", 32'(count), 0);
    chk("wrap_pulse", 32'(wrap), 1);
    cyc();
    chk("wrap_one_cycle", 32'(wrap), 0);

    // down one-shot
    clear = 1; cyc();
    load_val = 4'd2; dir = 1; auto_reload = 0;
    load = 1; cyc();
    start = 1; cyc();
    wait_tick(); chk("down_1", 32'(count), 1);
    wait_tick(); chk("down_0", 32'(count), 0);
    n = 0;
    do begin cyc(); n++; end while (state != 2'd3 && n < 12);
    chk("exp_state", 32'(state), 3);
    chk("exp_level", 32'(expired), 1);
    chk("exp_cnt", 32'(count), 0);
    chk("exp_no_tick", 32'(tick), 0);
    start = 1; cyc();
    chk("exp_start_ignored", 32'(state), 3);
    clear = 1; cyc();
    chk("exp_clear", 32'(state), 0);

    // down auto-reload, match on reload value
    auto_reload = 1; cmp_val = 4'd2;
    load = 1; cyc();
    start = 1; cyc();
    for (int i = 0; i < 6; i++) begin
      wait_tick();
      chk("reload_cnt", 32'(count), exp_cnt[i]);
      chk("reload_wrap", 32'(wrap), exp_wrap[i]);
      chk("reload_match", 32'(match), exp_wrap[i]);
    end

    // pause mid-period and resume
    for (int i = 0; i < 4; i++) cyc();
    stop = 1; cyc();
    for (int i = 0; i < 20; i++) cyc();
    chk("hold_state", 32'(state), 2);
    start = 1; cyc();
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 12);
    chk("resume_latency", n, 6);

    // start+stop together in RUN, then clear+load together
    start = 1; stop = 1; cyc();
    chk("start_stop", 32'(state), 2);
    load_val = 4'd5; clear = 1; load = 1; cyc();
    chk("clr_ld_cnt", 32'(count), 0);
    chk("clr_ld_state", 32'(state), 0);

`ifdef TICK_TIMER_LAP_EN
    dir = 0;
    load = 1; cyc();
    start = 1; cyc();
    for (int i = 0; i < 3; i++) cyc();
    lap = 1; cyc();
    chk("lap_valid", 32'(lap_valid), 1);
    chk("lap_count", 32'(lap_count), 5);
    cyc();
    chk("lap_valid_one", 32'(lap_valid), 0);
    wait_tick();
    chk("lap_continues", 32'(count), 6);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      clear = ($urandom_range(0, 79) == 0);
      load  = ($urandom_range(0, 39) == 0);
      lap   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) dir = 1'($urandom);
      if ($urandom_range(0, 49) == 0) auto_reload = 1'($urandom);
      load_val = 4'($urandom);
      cmp_val  = 4'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
